// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: cpu and host request ports plus the data-memory macro side.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu/host) arbiter for the single-port data memory: IDLE/ACCESS sequencer,
// round-robin ties by default; define DMEM_ARB_HOST_PRIO_EN to make the host win every tie.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          srst,
    dmem_arbiter_if.slave bus
);
    localparam logic SEL_CPU  = 1'b0;
    localparam logic SEL_HOST = 1'b1;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t                r_state, w_state_next;
    logic                  r_last_grant, w_last_grant_next;

    logic [1:0]            w_req;
    logic [1:0]            w_we;
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic                  w_winner;

    logic                  r_mem_en,    w_mem_en_next;
    logic                  r_mem_we,    w_mem_we_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;
    logic [1:0]            r_gnt,       w_gnt_next;
    logic [1:0]            r_rvalid,    w_rvalid_next;
    logic                  r_busy,      w_busy_next;

    logic [DATA_WIDTH-1:0] r_rdata_hold [2];
    logic [DATA_WIDTH-1:0] w_rdata      [2];

    // index 0 = cpu, index 1 = host
    assign w_req      = {bus.host_req, bus.cpu_req};
    assign w_we       = {bus.host_we,  bus.cpu_we};
    assign w_addr[0]  = bus.cpu_addr;
    assign w_addr[1]  = bus.host_addr;
    assign w_wdata[0] = bus.cpu_wdata;
    assign w_wdata[1] = bus.host_wdata;

    always_comb begin
        w_winner = SEL_CPU;
        if (w_req[0] && w_req[1]) begin
`ifdef DMEM_ARB_HOST_PRIO_EN
            w_winner = SEL_HOST;
`else
            w_winner = ~r_last_grant;
`endif
        end else if (w_req[1]) begin
            w_winner = SEL_HOST;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_mem_en_next     = 1'b0;
        w_mem_we_next     = 1'b0;
        w_mem_addr_next   = '0;
        w_mem_wdata_next  = '0;
        w_gnt_next        = 2'b00;
        w_rvalid_next     = 2'b00;
        w_busy_next       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_next            = ST_ACCESS;
                    w_last_grant_next       = w_winner;
                    w_mem_en_next           = 1'b1;
                    w_mem_we_next           = w_we[w_winner];
                    w_mem_addr_next         = w_addr[w_winner];
                    w_mem_wdata_next        = w_wdata[w_winner];
                    w_gnt_next[w_winner]    = 1'b1;
                    w_busy_next             = 1'b1;
                end
            end
            ST_ACCESS: begin
                // last_grant already names the requester being served
                w_state_next                = ST_IDLE;
                w_rvalid_next[r_last_grant] = ~r_mem_we;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= SEL_HOST;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_mem_en    <= w_mem_en_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_gnt       <= w_gnt_next;
            r_rvalid    <= w_rvalid_next;
            r_busy      <= w_busy_next;
        end
    end

    // The macro's read port is itself registered, so the rvalid cycle forwards it directly;
    // the hold register keeps the value stable afterwards.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_rdata_hold[gi] <= '0;
                end else if (r_rvalid[gi]) begin
                    r_rdata_hold[gi] <= bus.mem_rdata;
                end
            end
            assign w_rdata[gi] = r_rvalid[gi] ? bus.mem_rdata : r_rdata_hold[gi];
        end
    endgenerate

    assign bus.cpu_gnt     = r_gnt[0];
    assign bus.host_gnt    = r_gnt[1];
    assign bus.cpu_rvalid  = r_rvalid[0];
    assign bus.host_rvalid = r_rvalid[1];
    assign bus.cpu_rdata   = w_rdata[0];
    assign bus.host_rdata  = w_rdata[1];
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (reference memory, round-robin/host-priority tie rule).
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .srst(srst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // data memory macro: registered read, plus a preload port for the bench
    logic [DW-1:0] macro_mem [1024];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) macro_mem[pre_addr] <= pre_data;
        if (bus.mem_en) begin
            if (bus.mem_we) macro_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= macro_mem[bus.mem_addr];
        end
    end

    // winner of a tie given the previous winner (0 = cpu, 1 = host)
    function automatic logic tie_winner(input logic last);
`ifdef DMEM_ARB_HOST_PRIO_EN
        return 1'b1 | last;
`else
        return ~last;
`endif
    endfunction

    task automatic idle_inputs;
        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        srst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        logic exp_host;
        srst = 1'b1;
        bus.cpu_req = 1'b1;  bus.cpu_we = 1'b1;  bus.cpu_addr = 10'h3FF; bus.cpu_wdata = 32'hFFFF_FFFF;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'h155; bus.host_wdata = 32'h5555_5555;
        repeat (3) @(negedge clk);
        total++; if ({bus.mem_en, bus.mem_we, bus.busy} !== 3'b000) begin bad++;
            $display("FAIL reset_strobes got=%b exp=000", {bus.mem_en, bus.mem_we, bus.busy}); end
        total++; if (bus.mem_addr !== '0) begin bad++;
            $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== '0) begin bad++;
            $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
        total++; if ({bus.cpu_gnt, bus.host_gnt, bus.cpu_rvalid, bus.host_rvalid} !== 4'b0000) begin bad++;
            $display("FAIL reset_gnt_rvalid got=%b exp=0000",
                     {bus.cpu_gnt, bus.host_gnt, bus.cpu_rvalid, bus.host_rvalid}); end
        total++; if (bus.cpu_rdata !== '0) begin bad++;
            $display("FAIL reset_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        total++; if (bus.host_rdata !== '0) begin bad++;
            $display("FAIL reset_host_rdata got=%h exp=0", bus.host_rdata); end
        srst = 1'b0;
        exp_host = tie_winner(1'b1);
        @(negedge clk);
        total++; if ({bus.host_gnt, bus.cpu_gnt} !== {exp_host, ~exp_host}) begin bad++;
            $display("FAIL reset_first_tie got=%b exp=%b", {bus.host_gnt, bus.cpu_gnt}, {exp_host, ~exp_host}); end
    endtask

    task automatic test_cpu_write_read;
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'd5; bus.cpu_wdata = 32'h0000_000A;
        @(negedge clk);
        total++; if ({bus.cpu_gnt, bus.host_gnt, bus.mem_en, bus.mem_we, bus.busy} !== 5'b10111) begin bad++;
            $display("FAIL wr_strobes got=%b exp=10111", {bus.cpu_gnt, bus.host_gnt, bus.mem_en, bus.mem_we, bus.busy}); end
        total++; if (bus.mem_addr !== 10'd5 || bus.mem_wdata !== 32'h0000_000A) begin bad++;
            $display("FAIL wr_addr_data got=%h/%h exp=005/0000000a", bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        total++; if (bus.cpu_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin bad++;
            $display("FAIL wr_no_rvalid got=%b%b exp=00", bus.cpu_rvalid, bus.mem_en); end
        bus.cpu_we = 1'b0; bus.cpu_wdata = '0;
        @(negedge clk);
        total++; if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'd5) begin bad++;
            $display("FAIL rd_issue got=gnt%b we%b addr%h exp=gnt1 we0 addr005", bus.cpu_gnt, bus.mem_we, bus.mem_addr); end
        @(negedge clk);
        total++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h0000_000A) begin bad++;
            $display("FAIL rd_data got=%b/%h exp=1/0000000a", bus.cpu_rvalid, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        total++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0000_000A || bus.mem_en !== 1'b0) begin bad++;
            $display("FAIL rd_hold got=%b/%h/%b exp=0/0000000a/0", bus.cpu_rvalid, bus.cpu_rdata, bus.mem_en); end
    endtask

    task automatic test_simul_reads;
        int cg = -1, hg = -1, cr = -1, hr = -1;
        int ecg, ehg;
        logic [DW-1:0] crd = '0, hrd = '0;
        preload(10'd1, 32'h0000_000B);
        preload(10'd2, 32'h0000_0015);
        do_reset();
        bus.cpu_req = 1'b1;  bus.cpu_addr = 10'd1;
        bus.host_req = 1'b1; bus.host_addr = 10'd2;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (cg == c - 1) bus.cpu_req = 1'b0;
            if (hg == c - 1) bus.host_req = 1'b0;
            if (bus.cpu_gnt && cg < 0) cg = c;
            if (bus.host_gnt && hg < 0) hg = c;
            if (bus.cpu_rvalid && cr < 0) begin cr = c; crd = bus.cpu_rdata; end
            if (bus.host_rvalid && hr < 0) begin hr = c; hrd = bus.host_rdata; end
        end
        ecg = tie_winner(1'b1) ? 3 : 1;
        ehg = tie_winner(1'b1) ? 1 : 3;
        total++; if (cg != ecg) begin bad++; $display("FAIL simul_cpu_gnt_cycle got=%0d exp=%0d", cg, ecg); end
        total++; if (hg != ehg) begin bad++; $display("FAIL simul_host_gnt_cycle got=%0d exp=%0d", hg, ehg); end
        total++; if (cr != ecg + 1) begin bad++; $display("FAIL simul_cpu_rvalid_cycle got=%0d exp=%0d", cr, ecg + 1); end
        total++; if (hr != ehg + 1) begin bad++; $display("FAIL simul_host_rvalid_cycle got=%0d exp=%0d", hr, ehg + 1); end
        total++; if (crd !== 32'h0000_000B) begin bad++; $display("FAIL simul_cpu_rdata got=%h exp=0000000b", crd); end
        total++; if (hrd !== 32'h0000_0015) begin bad++; $display("FAIL simul_host_rdata got=%h exp=00000015", hrd); end
    endtask

    task automatic test_contention;
        int nc = 0, nh = 0, both = 0, repeats = 0, prev = -1, cgc = -1, hgc = -1;
        int exp_nc, exp_nh, exp_rep;
        logic cpu_seen = 1'b0;
        do_reset();
        bus.cpu_req = 1'b1;  bus.cpu_addr = 10'h010;
        bus.host_req = 1'b1; bus.host_addr = 10'h020;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cgc == c - 1) bus.cpu_addr = bus.cpu_addr + 10'd1;
            if (hgc == c - 1) bus.host_addr = bus.host_addr + 10'd1;
            if (bus.cpu_gnt) begin nc++; cgc = c; end
            if (bus.host_gnt) begin nh++; hgc = c; end
            if (bus.cpu_gnt && bus.host_gnt) both++;
            if (bus.cpu_gnt || bus.host_gnt) begin
                if (prev == int'(bus.host_gnt)) repeats++;
                prev = int'(bus.host_gnt);
            end
        end
`ifdef DMEM_ARB_HOST_PRIO_EN
        exp_nc = 0; exp_nh = 10; exp_rep = 9;
`else
        exp_nc = 5; exp_nh = 5; exp_rep = 0;
`endif
        total++; if (nc != exp_nc) begin bad++; $display("FAIL cont_cpu_gnts got=%0d exp=%0d", nc, exp_nc); end
        total++; if (nh != exp_nh) begin bad++; $display("FAIL cont_host_gnts got=%0d exp=%0d", nh, exp_nh); end
        total++; if (both != 0) begin bad++; $display("FAIL cont_both_gnt got=%0d exp=0", both); end
        total++; if (repeats != exp_rep) begin bad++; $display("FAIL cont_repeat_winner got=%0d exp=%0d", repeats, exp_rep); end
        bus.host_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt) cpu_seen = 1'b1;
        end
        total++; if (cpu_seen !== 1'b1) begin bad++; $display("FAIL cont_cpu_after_host_drop got=%b exp=1", cpu_seen); end
    endtask

    task automatic test_reset_during_access;
        logic exp_host;
        preload(10'd7, 32'hDEAD_BEEF);
        do_reset();
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'd7;
        @(negedge clk);
        total++; if (bus.host_gnt !== 1'b1) begin bad++; $display("FAIL rst_acc_host_gnt got=%b exp=1", bus.host_gnt); end
        srst = 1'b1;
        bus.host_req = 1'b0;
        @(negedge clk);
        total++; if ({bus.mem_en, bus.busy, bus.cpu_gnt, bus.host_gnt, bus.host_rvalid} !== 5'b00000) begin bad++;
            $display("FAIL rst_acc_outputs got=%b exp=00000",
                     {bus.mem_en, bus.busy, bus.cpu_gnt, bus.host_gnt, bus.host_rvalid}); end
        total++; if (bus.mem_addr !== '0 || bus.host_rdata !== '0) begin bad++;
            $display("FAIL rst_acc_addr_rdata got=%h/%h exp=0/0", bus.mem_addr, bus.host_rdata); end
        srst = 1'b0;
        @(negedge clk);
        total++; if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== '0) begin bad++;
            $display("FAIL rst_acc_no_rvalid got=%b/%h exp=0/0", bus.host_rvalid, bus.host_rdata); end
        bus.cpu_req = 1'b1; bus.cpu_addr = 10'd3;
        bus.host_req = 1'b1; bus.host_addr = 10'd4;
        exp_host = tie_winner(1'b1);
        @(negedge clk);
        total++; if ({bus.host_gnt, bus.cpu_gnt} !== {exp_host, ~exp_host}) begin bad++;
            $display("FAIL rst_acc_next_tie got=%b exp=%b", {bus.host_gnt, bus.cpu_gnt}, {exp_host, ~exp_host}); end
    endtask

    task automatic test_host_stream;
        int gc [4];
        int k = 0;
        logic pend = 1'b0;
        for (int i = 0; i < 4; i++) gc[i] = -1;
        do_reset();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 10'd0; bus.host_wdata = 32'hA000_0000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (pend) begin
                if (k < 4) begin bus.host_addr = AW'(k); bus.host_wdata = 32'hA000_0000 + 32'(k); end
                else bus.host_req = 1'b0;
                pend = 1'b0;
            end
            if (bus.host_gnt) begin
                if (k < 4) begin
                    gc[k] = c;
                    total++; if (bus.mem_addr !== AW'(k) || bus.mem_we !== 1'b1) begin bad++;
                        $display("FAIL stream_addr[%0d] got=%h/%b exp=%h/1", k, bus.mem_addr, bus.mem_we, AW'(k)); end
                    total++; if (bus.mem_wdata !== 32'hA000_0000 + 32'(k)) begin bad++;
                        $display("FAIL stream_wdata[%0d] got=%h exp=%h", k, bus.mem_wdata, 32'hA000_0000 + 32'(k)); end
                end
                k++;
                pend = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (gc[i] != 2 * i + 1) begin bad++;
                $display("FAIL stream_gnt_cycle[%0d] got=%0d exp=%0d", i, gc[i], 2 * i + 1); end
        end
        total++; if (k != 4) begin bad++; $display("FAIL stream_gnt_count got=%0d exp=4", k); end
    endtask

    task automatic test_random;
        logic [DW-1:0] ref_mem [16];
        logic [1:0]    req = 2'b00, we = 2'b00, retire = 2'b00;
        logic [3:0]    addr [2];
        logic [DW-1:0] wd [2];
        logic [1:0]    e_gnt = 2'b00, e_rv = 2'b00, n_gnt, n_rv;
        logic [DW-1:0] e_rd [2];
        logic          e_en = 1'b0, e_we = 1'b0, n_en, n_we, acc_we = 1'b0, last = 1'b1, w;
        logic [AW-1:0] e_addr = '0, n_addr;
        logic [DW-1:0] e_wd = '0, n_wd, acc_rd = '0;
        logic          og, orv;
        logic [DW-1:0] ord;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            preload(AW'(i), ref_mem[i]);
        end
        for (int p = 0; p < 2; p++) begin addr[p] = '0; wd[p] = '0; e_rd[p] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                og  = p ? bus.host_gnt    : bus.cpu_gnt;
                orv = p ? bus.host_rvalid : bus.cpu_rvalid;
                ord = p ? bus.host_rdata  : bus.cpu_rdata;
                total++; if (og !== e_gnt[p]) begin bad++;
                    $display("FAIL rnd_gnt[%0d] cyc=%0d got=%b exp=%b", p, cyc, og, e_gnt[p]); end
                total++; if (orv !== e_rv[p]) begin bad++;
                    $display("FAIL rnd_rvalid[%0d] cyc=%0d got=%b exp=%b", p, cyc, orv, e_rv[p]); end
                total++; if (ord !== e_rd[p]) begin bad++;
                    $display("FAIL rnd_rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, ord, e_rd[p]); end
            end
            total++; if (bus.mem_en !== e_en || bus.busy !== e_en || bus.mem_we !== e_we) begin bad++;
                $display("FAIL rnd_en_busy_we cyc=%0d got=%b%b%b exp=%b%b%b", cyc,
                         bus.mem_en, bus.busy, bus.mem_we, e_en, e_en, e_we); end
            total++; if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wd) begin bad++;
                $display("FAIL rnd_addr_wdata cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         bus.mem_addr, bus.mem_wdata, e_addr, e_wd); end

            // requesters: change only in the cycle after their grant, or start when idle
            for (int p = 0; p < 2; p++) begin
                if (retire[p] || !req[p]) begin
                    if ($urandom_range(0, 2) != 0 || (retire[p] && $urandom_range(0, 1) != 0)) begin
                        req[p]  = 1'b1;
                        we[p]   = 1'($urandom_range(0, 1));
                        addr[p] = 4'($urandom_range(0, 15));
                        wd[p]   = $urandom;
                    end else begin
                        req[p] = 1'b0;
                    end
                    retire[p] = 1'b0;
                end
            end
            bus.cpu_req  = req[0]; bus.cpu_we  = we[0]; bus.cpu_addr  = AW'(addr[0]); bus.cpu_wdata  = wd[0];
            bus.host_req = req[1]; bus.host_we = we[1]; bus.host_addr = AW'(addr[1]); bus.host_wdata = wd[1];

            n_gnt = 2'b00; n_rv = 2'b00; n_en = 1'b0; n_we = 1'b0; n_addr = '0; n_wd = '0;
            if (e_gnt != 2'b00) begin
                w = e_gnt[1];
                retire[w] = 1'b1;
                if (!acc_we) begin n_rv[w] = 1'b1; e_rd[w] = acc_rd; end
            end else if (req != 2'b00) begin
                w = (req == 2'b11) ? tie_winner(last) : req[1];
                last     = w;
                n_gnt[w] = 1'b1;
                n_en     = 1'b1;
                n_we     = we[w];
                n_addr   = AW'(addr[w]);
                n_wd     = wd[w];
                acc_we   = we[w];
                if (we[w]) ref_mem[addr[w]] = wd[w];
                else       acc_rd = ref_mem[addr[w]];
            end
            e_gnt = n_gnt; e_rv = n_rv; e_en = n_en; e_we = n_we; e_addr = n_addr; e_wd = n_wd;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_simul_reads();
        test_contention();
        test_reset_during_access();
        test_host_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
